bcd_updown_counter: RTL and testbench

//   Cascadable multi-digit BCD up/down counter: the producer side of the >=10 digit check.

---
 rtl/bcd_updown_counter.sv | 84 ++++++++
 tb/tb_bcd_updown_counter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// Cascadable multi-digit BCD up/down counter with validated parallel load.
// Every digit register stays within 0..9; loads containing a code >= 10 are rejected.
module bcd_updown_counter #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc_out,
  output logic                  load_err
);

  logic [4*DIGITS-1:0] countQ, countD;
  logic                loadErrQ, loadErrD;
  logic [4*DIGITS-1:0] stepped;
  logic                loadBad;
  logic                allNine;
  logic                allZero;

  // A digit steps only while every lower digit sits at its wrap value (9 up, 0 down).
  always_comb begin
    logic       ripple;
    logic [3:0] digit;
    stepped = countQ;
    ripple  = 1'b1;
    digit   = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = countQ[4*i +: 4];
      if (ripple) begin
        if (up) begin
          stepped[4*i +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
        end else begin
          stepped[4*i +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
        end
      end
      ripple = ripple & (up ? (digit == 4'd9) : (digit == 4'd0));
    end
  end

  always_comb begin
    loadBad = 1'b0;
    allNine = 1'b1;
    allZero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      loadBad = loadBad | (load_val[4*i+3] & (load_val[4*i+2] | load_val[4*i+1]));
      allNine = allNine & (countQ[4*i +: 4] == 4'd9);
      allZero = allZero & (countQ[4*i +: 4] == 4'd0);
    end
  end

  // Load takes priority over counting; en is ignored on any load cycle.
  always_comb begin
    countD   = countQ;
    loadErrD = 1'b0;
    if (load) begin
      if (loadBad) begin
        loadErrD = 1'b1;
      end else begin
        countD = load_val;
      end
    end else if (en) begin
      countD = stepped;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      countQ   <= '0;
      loadErrQ <= 1'b0;
    end else begin
      countQ   <= countD;
      loadErrQ <= loadErrD;
    end
  end

  assign count    = countQ;
  assign load_err = loadErrQ;
  assign tc_out   = en & ~load & ~rst & (up ? allNine : allZero);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed scoreboard bench for bcd_updown_counter (DIGITS=2) plus a two-stage cascade.
module tb_bcd_updown_counter;

  localparam int DIGITS = 2;

  typedef struct {
    logic [7:0] cnt;
    logic       err;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       tc_out, load_err;

  logic       cRst, cLoad, cEn, cUp;
  logic [7:0] cLoVal, cHiVal;
  logic [7:0] loCount, hiCount;
  logic       loTc, hiTc, loErr, hiErr;

  int   total = 0;
  int   bad   = 0;
  int   modelVal = 0;
  logic modelErr = 1'b0;
  exp_t sbQ[$];

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count), .tc_out(tc_out), .load_err(load_err)
  );

  bcd_updown_counter #(.DIGITS(2)) uLo (
    .clk(clk), .rst(cRst), .en(cEn), .up(cUp), .load(cLoad), .load_val(cLoVal),
    .count(loCount), .tc_out(loTc), .load_err(loErr)
  );

  bcd_updown_counter #(.DIGITS(2)) uHi (
    .clk(clk), .rst(cRst), .en(loTc), .up(cUp), .load(cLoad), .load_val(cHiVal),
    .count(hiCount), .tc_out(hiTc), .load_err(hiErr)
  );

  function automatic logic [7:0] toBcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic isValid(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic int fromBcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sbQ.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sbQ.pop_front();
      checkValue({e.tag, "_count"}, count, e.cnt);
      checkValue({e.tag, "_err"}, {7'd0, load_err}, {7'd0, e.err});
    end
  endtask

  // One clock of stimulus: tc_out is checked before the edge, count/load_err after it.
  task automatic applyStimulus(input logic r, input logic l, input logic e, input logic u,
                               input logic [7:0] v, input string tag);
    logic expTc;
    @(negedge clk);
    rst = r; load = l; en = e; up = u; load_val = v;
    expTc = e & ~l & ~r & (u ? (modelVal == 99) : (modelVal == 0));
    #1;
    checkValue({tag, "_tc"}, {7'd0, tc_out}, {7'd0, expTc});
    if (r) begin
      modelVal = 0;
      modelErr = 1'b0;
    end else if (l) begin
      if (isValid(v)) begin
        modelVal = fromBcd(v);
        modelErr = 1'b0;
      end else begin
        modelErr = 1'b1;
      end
    end else begin
      modelErr = 1'b0;
      if (e) modelVal = u ? (modelVal + 1) % 100 : (modelVal + 99) % 100;
    end
    sbQ.push_back('{toBcd(modelVal), modelErr, tag});
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; en = 1'b0; up = 1'b1; load_val = 8'h00;
    cRst = 1'b1; cLoad = 1'b0; cEn = 1'b0; cUp = 1'b1; cLoVal = 8'h00; cHiVal = 8'h00;

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h42, "reset");

    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "count_up");

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h10, "load10");
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "count_down");

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h37, "load37");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h3A, "reject3A");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, "hold_a");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'hB2, "rejectB2");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, "hold_b");

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h95, "load95_en");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "toggle_1");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "toggle_2");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "toggle_3");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "toggle_4");

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h99, "load99");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h99, "tc_masked_load");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, "tc_masked_rst");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "wrap_down");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "wrap_up");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h55, "load55");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h66, "rst_over_load");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "after_rst");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, "rejectFF");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "hold_c");

    // Cascade: lower 99, upper 09; one up step must roll both on the same edge.
    @(negedge clk);
    cRst = 1'b0; cLoad = 1'b1; cLoVal = 8'h99; cHiVal = 8'h09;
    @(negedge clk);
    cLoad = 1'b0; cEn = 1'b1; cUp = 1'b1;
    #1;
    checkValue("cascade_lo_tc", {7'd0, loTc}, 8'd1);
    checkValue("cascade_hi_pre", hiCount, 8'h09);
    @(posedge clk);
    #1;
    checkValue("cascade_lo", loCount, 8'h00);
    checkValue("cascade_hi", hiCount, 8'h10);
    @(negedge clk);
    cEn = 1'b0;
    #1;
    checkValue("cascade_hi_hold", hiCount, 8'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
